// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e     : arbitration priority state (CPU first, host first, host burst lock)
//   DefaultMaxLock  : default bound on consecutive locked host grants against a waiting CPU
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StCpuPri   = 2'd0,
    StHostPri  = 2'd1,
    StHostLock = 2'd2
  } arb_state_e;

  localparam int unsigned DefaultMaxLock = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the single-cycle CPU core and a host/DMA port.
// Round-robin priority on contention; the host may hold the port for a burst with host_lock,
// bounded to MAX_LOCK consecutive grants while the CPU is waiting.
// Ports:
//   clk, reset                    clock; synchronous active-low reset
//   cpu_req/we/addr/wdata         CPU access request (held by the core while stalled)
//   cpu_rdata, cpu_stall          combinational read data; stall when the CPU loses the port
//   host_req/we/lock/addr/wdata   host access request, burst lock request
//   host_gnt                      combinational accept of the host request
//   host_rdata, host_rvalid       registered read return, one cycle after a granted host read
//   mem_addr/wdata/write/read     muxed request to the data memory
//   mem_rdata                     combinational read data from the data memory
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = DefaultMaxLock,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LockLimit = CNT_W'(MAX_LOCK);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             host_rvalid_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic cpu_gnt;
  logic contested;
  logic forced_yield;

  // Arbitration, memory mux and next-state in one block.
  always_comb begin
    cpu_gnt      = 1'b0;
    host_gnt     = 1'b0;
    forced_yield = 1'b0;
    contested    = cpu_req & host_req;
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_write    = 1'b0;
    mem_read     = 1'b0;

    if (contested) begin
      case (state_q)
        StCpuPri:  cpu_gnt = 1'b1;
        StHostPri: host_gnt = 1'b1;
        StHostLock: begin
          if (lock_cnt_q < LockLimit) begin
            host_gnt = 1'b1;
          end else begin
            cpu_gnt      = 1'b1;
            forced_yield = 1'b1;
          end
        end
        default:   cpu_gnt = 1'b1;
      endcase
    end else begin
      cpu_gnt  = cpu_req;
      host_gnt = host_req;
    end

    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_write = cpu_we;
      mem_read  = ~cpu_we;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_write = host_we;
      mem_read  = ~host_we;
    end

    // Burst end takes precedence, then the forced yield, then lock entry/continuation,
    // then plain round-robin on contested grants.
    if ((state_q == StHostLock) && (!host_req || !host_lock)) begin
      state_d    = StCpuPri;
      lock_cnt_d = '0;
    end else if (forced_yield) begin
      state_d    = StCpuPri;
      lock_cnt_d = '0;
    end else if (host_gnt && host_lock) begin
      state_d = StHostLock;
      if (state_q != StHostLock) begin
        lock_cnt_d = '0;
      end else if (cpu_req) begin
        // Only grants taken against a waiting CPU count; an idle CPU lets the burst run.
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end else if (contested && cpu_gnt) begin
      state_d = StHostPri;
    end else if (contested && host_gnt) begin
      state_d = StCpuPri;
    end

    cpu_stall = cpu_req & ~cpu_gnt;
    cpu_rdata = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StCpuPri;
      lock_cnt_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      host_rvalid_q <= host_gnt & ~host_we;
      if (host_gnt && !host_we) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed stimulus pushes expected per-cycle responses
// into a queue; a negedge monitor pops and compares. A small word memory model sits on the
// mem_* side.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_req, host_we, host_lock;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        host_gnt, host_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_LOCK(8),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_lock  (host_lock),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory; reset reloads the two preset words used by read tests.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!reset) begin
      mem[8]  <= 32'h0000_1234;
      mem[12] <= 32'hCAFE_0030;
    end else if (mem_write === 1'b1) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  typedef struct {
    string       name;
    bit          gnt_chk;
    logic        stall;
    logic        hgnt;
    bit          rv_chk;
    logic        rvalid;
    bit          hrd_chk;
    logic [31:0] hrd;
    bit          crd_chk;
    logic [31:0] crd;
    bit          mem_chk;
    logic        mrd;
    logic        mwr;
    logic [31:0] maddr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.gnt_chk) begin
        cmp({mon_e.name, ".cpu_stall"}, {31'b0, cpu_stall}, {31'b0, mon_e.stall});
        cmp({mon_e.name, ".host_gnt"}, {31'b0, host_gnt}, {31'b0, mon_e.hgnt});
      end
      if (mon_e.rv_chk)
        cmp({mon_e.name, ".host_rvalid"}, {31'b0, host_rvalid}, {31'b0, mon_e.rvalid});
      if (mon_e.hrd_chk) cmp({mon_e.name, ".host_rdata"}, host_rdata, mon_e.hrd);
      if (mon_e.crd_chk) cmp({mon_e.name, ".cpu_rdata"}, cpu_rdata, mon_e.crd);
      if (mon_e.mem_chk) begin
        cmp({mon_e.name, ".mem_read"}, {31'b0, mem_read}, {31'b0, mon_e.mrd});
        cmp({mon_e.name, ".mem_write"}, {31'b0, mem_write}, {31'b0, mon_e.mwr});
        cmp({mon_e.name, ".mem_addr"}, mem_addr, mon_e.maddr);
      end
    end
  end

  function automatic exp_t mk(input string nm, input logic stall, input logic hgnt);
    exp_t e;
    e.name    = nm;
    e.gnt_chk = 1'b1;
    e.stall   = stall;
    e.hgnt    = hgnt;
    e.rv_chk  = 1'b0;
    e.rvalid  = 1'b0;
    e.hrd_chk = 1'b0;
    e.hrd     = '0;
    e.crd_chk = 1'b0;
    e.crd     = '0;
    e.mem_chk = 1'b0;
    e.mrd     = 1'b0;
    e.mwr     = 1'b0;
    e.maddr   = '0;
    return e;
  endfunction

  task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(input logic r, input logic w, input logic l, input logic [31:0] a,
                          input logic [31:0] d);
    host_req = r; host_we = w; host_lock = l; host_addr = a; host_wdata = d;
  endtask

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    reset = 1'b0;
    set_cpu(1'b1, 1'b0, 32'h0, 32'h0);
    set_host(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset release with both requesting, then alternation on contention (host reads 0x30).
    e = mk("rst_c0", 1'b0, 1'b0);
    e.rv_chk = 1'b1; e.rvalid = 1'b0; e.hrd_chk = 1'b1; e.hrd = 32'h0;
    step(e);
    e = mk("alt_c1", 1'b1, 1'b1); e.rv_chk = 1'b1; e.rvalid = 1'b0; step(e);
    e = mk("alt_c2", 1'b0, 1'b0);
    e.rv_chk = 1'b1; e.rvalid = 1'b1; e.hrd_chk = 1'b1; e.hrd = 32'hCAFE_0030;
    step(e);
    e = mk("alt_c3", 1'b1, 1'b1); e.rv_chk = 1'b1; e.rvalid = 1'b0; step(e);

    // CPU-only store then load.
    set_host(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    e = mk("cpu_st", 1'b0, 1'b0);
    e.rv_chk = 1'b1; e.rvalid = 1'b1; e.hrd_chk = 1'b1; e.hrd = 32'hCAFE_0030;
    e.mem_chk = 1'b1; e.mrd = 1'b0; e.mwr = 1'b1; e.maddr = 32'h10;
    step(e);
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    e = mk("cpu_ld", 1'b0, 1'b0);
    e.rv_chk = 1'b1; e.rvalid = 1'b0; e.crd_chk = 1'b1; e.crd = 32'hDEAD_BEEF;
    e.mem_chk = 1'b1; e.mrd = 1'b1; e.mwr = 1'b0; e.maddr = 32'h10;
    step(e);

    // Idle: memory side quiet.
    set_cpu(1'b0, 1'b0, 32'h10, 32'h0);
    e = mk("idle", 1'b0, 1'b0);
    e.mem_chk = 1'b1; e.mrd = 1'b0; e.mwr = 1'b0; e.maddr = 32'h0;
    step(e);

    // Host read of 0x20: one-cycle rvalid pulse with registered data.
    set_host(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    e = mk("h_rd", 1'b0, 1'b1);
    e.mem_chk = 1'b1; e.mrd = 1'b1; e.mwr = 1'b0; e.maddr = 32'h20;
    step(e);
    set_host(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    e = mk("h_rd_ret", 1'b0, 1'b0);
    e.rv_chk = 1'b1; e.rvalid = 1'b1; e.hrd_chk = 1'b1; e.hrd = 32'h0000_1234;
    step(e);
    e = mk("h_rd_pulse_end", 1'b0, 1'b0); e.rv_chk = 1'b1; e.rvalid = 1'b0; step(e);

    // Host write then CPU load of the same word.
    set_host(1'b1, 1'b1, 1'b0, 32'h40, 32'h0000_55AA);
    e = mk("h_wr", 1'b0, 1'b1);
    e.mem_chk = 1'b1; e.mrd = 1'b0; e.mwr = 1'b1; e.maddr = 32'h40;
    step(e);
    set_host(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    e = mk("h_wr_cpu_ld", 1'b0, 1'b0);
    e.rv_chk = 1'b1; e.rvalid = 1'b0; e.crd_chk = 1'b1; e.crd = 32'h0000_55AA;
    step(e);

    // Locked host burst against a waiting CPU.
    set_host(1'b1, 1'b1, 1'b1, 32'h50, 32'h0000_0050);
    e = mk("lk_cpu_first", 1'b0, 1'b0); step(e);
    e = mk("lk_enter", 1'b1, 1'b1); step(e);
    for (int i = 0; i < 8; i++) begin
      e = mk($sformatf("lk_burst%0d", i), 1'b1, 1'b1);
      step(e);
    end
    e = mk("lk_yield", 1'b0, 1'b0); step(e);

    // Idle CPU: burst runs unbounded and the counter does not advance.
    set_cpu(1'b0, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 10; i++) begin
      e = mk($sformatf("lk_idle%0d", i), 1'b0, 1'b1);
      step(e);
    end
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 8; i++) begin
      e = mk($sformatf("lk_burst2_%0d", i), 1'b1, 1'b1);
      step(e);
    end
    e = mk("lk_yield2", 1'b0, 1'b0); step(e);
    set_host(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    e = mk("lk_release", 1'b0, 1'b0); step(e);

    // Reset on the cycle a host read is granted: read is dropped, priority back to CPU.
    set_host(1'b1, 1'b1, 1'b0, 32'h60, 32'h0);
    e = mk("pre_rst_cpu", 1'b0, 1'b0); step(e);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_host(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    reset = 1'b0;
    e = mk("rst_hrd", 1'b0, 1'b1); e.rv_chk = 1'b1; e.rvalid = 1'b0; step(e);
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    e = mk("post_rst", 1'b0, 1'b0);
    e.rv_chk = 1'b1; e.rvalid = 1'b0; e.hrd_chk = 1'b1; e.hrd = 32'h0;
    step(e);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_host(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    e = mk("post_rst_idle", 1'b0, 1'b0); e.rv_chk = 1'b1; e.rvalid = 1'b0; step(e);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
